alu_result_demux: RTL and testbench

ALU_RESULT_DEMUX -- requirements
Module: alu_result_demux

---
 rtl/alu_result_demux_pkg.sv | 29 ++
 rtl/alu_result_demux_slot.sv | 119 +++++++++++
 rtl/alu_result_demux.sv | 92 +++++++++
 tb/tb_alu_result_demux.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_result_demux_pkg.sv
// alu_result_demux_pkg
//   Shared encodings for the ALU result demultiplexer:
//     ch_e          - destination channel selector values CH0..CH3
//     slot_state_e  - per-channel holding state EMPTY / FULL
//     ch_onehot()   - selector to one-hot channel mask
package alu_result_demux_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic [1:0] {
        CH0 = 2'd0,
        CH1 = 2'd1,
        CH2 = 2'd2,
        CH3 = 2'd3
    } ch_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [1:0] sel);
        logic [NUM_CH-1:0] mask;
        mask = '0;
        mask[sel] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/alu_result_demux_slot.sv
// demux_out_slot
//   One output channel of the ALU result demultiplexer: EMPTY/FULL state,
//   held data word, transfer counter and (optionally) result flags.
//
//   Optional feature macro: ALU_RESULT_DEMUX_FLAGS_EN adds zero_flag/neg_flag.
//
//   Handshake: a word is loaded when load is high on a rising clk edge
//   (the parent has already qualified it with in_valid & in_ready and the
//   selector). A transfer happens when out_valid and out_ready are both high
//   on a rising clk edge; out_valid never depends on out_ready.
//
//   Ports:
//     clk, reset     - clock, asynchronous active-high reset
//     load           - accept data_in into this channel at this edge
//     data_in        - word to capture
//     out_ready      - consumer takes the held word this cycle
//     out_valid      - channel holds a word (state FULL)
//     data_out       - held word
//     count          - completed transfer count, wraps
//     state          - current FSM state (debug visibility)
//     zero_flag      - held word is zero      (flags build only)
//     neg_flag       - held word MSB          (flags build only)
module demux_out_slot
    import alu_result_demux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_out,
    output logic [CNT_W-1:0] count,
`ifdef ALU_RESULT_DEMUX_FLAGS_EN
    output logic             zero_flag,
    output logic             neg_flag,
`endif
    output slot_state_e      state
);

    slot_state_e      state_q;
    slot_state_e      state_d;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] count_q;
    logic             transfer;

    assign transfer = (state_q == SLOT_FULL) && out_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a load always wins, so drain+fill on one edge stays FULL
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (load) state_d = SLOT_FULL;
            SLOT_FULL:  if (transfer && !load) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    // Output logic
    always_comb begin
        out_valid = (state_q == SLOT_FULL);
    end

    // Data register: only a load changes it, so the word holds while FULL
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (transfer) begin
            count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef ALU_RESULT_DEMUX_FLAGS_EN
    logic zero_q;
    logic neg_q;

    // Flags are captured with the word and cleared when the slot empties
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (load) begin
            zero_q <= (data_in == '0);
            neg_q  <= data_in[WIDTH-1];
        end else if (transfer) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end
    end

    assign zero_flag = zero_q;
    assign neg_flag  = neg_q;
`endif

    assign data_out = data_q;
    assign count    = count_q;
    assign state    = state_q;

endmodule

// File: rtl/alu_result_demux.sv
// alu_result_demux
//   Routes each accepted ALU result word to one of four output channels,
//   each of which holds one word until its consumer takes it.
//
//   Optional feature macro: ALU_RESULT_DEMUX_FLAGS_EN adds zero_flag/neg_flag.
//
//   Handshake: input word accepted when in_valid & in_ready on a rising edge;
//   channel k transfers when out_valid[k] & out_ready[k] on a rising edge.
//   in_ready depends only on the selected channel's state and out_ready,
//   never on in_valid; out_valid never depends on out_ready.
//
//   Ports:
//     clk, reset            - clock, asynchronous active-high reset
//     in_valid / in_ready   - input handshake
//     selector              - destination channel for the input word
//     data_in               - input word
//     out_valid / out_ready - per-channel output handshake (bit k = channel k)
//     data_out0..3          - per-channel held word
//     count0..3             - per-channel completed transfer count
//     zero_flag, neg_flag   - per-channel flags (flags build only)
//     state_dbg             - per-channel FSM state, 2 bits per channel
module alu_result_demux
    import alu_result_demux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       selector,
    input  logic [WIDTH-1:0] data_in,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] data_out0,
    output logic [WIDTH-1:0] data_out1,
    output logic [WIDTH-1:0] data_out2,
    output logic [WIDTH-1:0] data_out3,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1,
    output logic [CNT_W-1:0] count2,
    output logic [CNT_W-1:0] count3,
`ifdef ALU_RESULT_DEMUX_FLAGS_EN
    output logic [3:0]       zero_flag,
    output logic [3:0]       neg_flag,
`endif
    output logic [7:0]       state_dbg
);

    logic             accept;
    logic [3:0]       load;
    logic [WIDTH-1:0] data_arr  [NUM_CH];
    logic [CNT_W-1:0] count_arr [NUM_CH];
    slot_state_e      state_arr [NUM_CH];

    assign in_ready = !out_valid[selector] || out_ready[selector];
    assign accept   = in_valid && in_ready;
    assign load     = accept ? ch_onehot(selector) : 4'b0000;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_out_slot #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (load[k]),
            .data_in   (data_in),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .data_out  (data_arr[k]),
            .count     (count_arr[k]),
`ifdef ALU_RESULT_DEMUX_FLAGS_EN
            .zero_flag (zero_flag[k]),
            .neg_flag  (neg_flag[k]),
`endif
            .state     (state_arr[k])
        );
        assign state_dbg[2*k +: 2] = {1'b0, state_arr[k]};
    end

    assign data_out0 = data_arr[0];
    assign data_out1 = data_arr[1];
    assign data_out2 = data_arr[2];
    assign data_out3 = data_arr[3];
    assign count0    = count_arr[0];
    assign count1    = count_arr[1];
    assign count2    = count_arr[2];
    assign count3    = count_arr[3];

endmodule

// File: tb/tb_alu_result_demux.sv
module tb_alu_result_demux;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       selector;
  logic [WIDTH-1:0] data_in;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] data_out0, data_out1, data_out2, data_out3;
  logic [CNT_W-1:0] count0, count1, count2, count3;
  logic [7:0]       state_dbg;
`ifdef ALU_RESULT_DEMUX_FLAGS_EN
  logic [3:0]       zero_flag;
  logic [3:0]       neg_flag;
`endif

  alu_result_demux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .selector  (selector),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out0 (data_out0),
    .data_out1 (data_out1),
    .data_out2 (data_out2),
    .data_out3 (data_out3),
    .count0    (count0),
    .count1    (count1),
    .count2    (count2),
    .count3    (count3),
`ifdef ALU_RESULT_DEMUX_FLAGS_EN
    .zero_flag (zero_flag),
    .neg_flag  (neg_flag),
`endif
    .state_dbg (state_dbg)
  );

  logic [WIDTH-1:0] dout [4];
  logic [CNT_W-1:0] cout [4];
  assign dout[0] = data_out0;
  assign dout[1] = data_out1;
  assign dout[2] = data_out2;
  assign dout[3] = data_out3;
  assign cout[0] = count0;
  assign cout[1] = count1;
  assign cout[2] = count2;
  assign cout[3] = count3;

  // ---------------- reference model ----------------
  // Each channel is a one-word box: full flag, word, transfer tally.
  bit               m_full [4];
  logic [WIDTH-1:0] m_data [4];
  int               m_cnt  [4];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 0;
      m_data[k] = '0;
      m_cnt[k]  = 0;
    end
  endtask

  function automatic bit model_ready();
    return !m_full[selector] || out_ready[selector];
  endfunction

  // Apply what one rising edge does to the boxes
  task automatic model_edge();
    bit acc;
    acc = in_valid && model_ready();
    for (int k = 0; k < 4; k++) begin
      bit xfer;
      xfer = m_full[k] && out_ready[k];
      if (xfer) m_cnt[k] = (m_cnt[k] + 1) % (1 << CNT_W);
      if (acc && selector == k[1:0]) begin
        m_full[k] = 1;
        m_data[k] = data_in;
      end else if (xfer) begin
        m_full[k] = 0;
      end
    end
  endtask

  // Compare every meaningful output against the model
  task automatic compare_all();
    logic [3:0] exp_v;
    chk("in_ready", {63'd0, in_ready}, {63'd0, model_ready()});
    for (int k = 0; k < 4; k++) exp_v[k] = m_full[k];
    chk("out_valid", {60'd0, out_valid}, {60'd0, exp_v});
    for (int k = 0; k < 4; k++) begin
      if (m_full[k]) chk($sformatf("data_out%0d", k), {32'd0, dout[k]}, {32'd0, m_data[k]});
      chk($sformatf("count%0d", k), {56'd0, cout[k]}, 64'(m_cnt[k]));
    end
`ifdef ALU_RESULT_DEMUX_FLAGS_EN
    begin
      logic [3:0] ez, en;
      for (int k = 0; k < 4; k++) begin
        ez[k] = m_full[k] && (m_data[k] == 0);
        en[k] = m_full[k] && m_data[k][WIDTH-1];
      end
      chk("zero_flag", {60'd0, zero_flag}, {60'd0, ez});
      chk("neg_flag", {60'd0, neg_flag}, {60'd0, en});
    end
`endif
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the next one.
  task automatic step(input bit v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                      input logic [3:0] ordy);
    in_valid  = v;
    selector  = s;
    data_in   = d;
    out_ready = ordy;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic sync_reset_pulse();
    in_valid  = 0;
    out_ready = '0;
    reset     = 1;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    in_valid  = 0;
    selector  = 0;
    data_in   = '0;
    out_ready = '0;
    reset     = 1;
    model_reset();

    // Reset state, before any clock edge
    #2;
    chk("rst_out_valid", {60'd0, out_valid}, 64'h0);
    chk("rst_data_out0", {32'd0, data_out0}, 64'h0);
    chk("rst_count3", {56'd0, count3}, 64'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;

    // Single route to channel 2
    step(1, 2'd2, 32'hDEAD_BEEF, 4'b0000);
    chk("route_out_valid", {60'd0, out_valid}, 64'b0100);
    chk("route_data_out2", {32'd0, data_out2}, 64'hDEAD_BEEF);

    // Backpressure on channel 1
    step(1, 2'd1, 32'h1111_1111, 4'b0000);
    in_valid = 1; selector = 2'd1; data_in = 32'h2222_2222; out_ready = 4'b0000;
    #1;
    chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    step(1, 2'd1, 32'h2222_2222, 4'b0000);
    chk("bp_data_held", {32'd0, data_out1}, 64'h1111_1111);
    out_ready = 4'b0010;
    #1;
    chk("bp_in_ready_high", {63'd0, in_ready}, 64'd1);
    step(1, 2'd1, 32'h2222_2222, 4'b0010);
    chk("bp_data_new", {32'd0, data_out1}, 64'h2222_2222);
    chk("bp_count1", {56'd0, count1}, 64'd1);

    // Simultaneous drain and fill on channel 0
    step(1, 2'd0, 32'h1, 4'b0000);
    step(1, 2'd0, 32'h2, 4'b0001);
    chk("df_valid0", {63'd0, out_valid[0]}, 64'd1);
    chk("df_data0", {32'd0, data_out0}, 64'h2);
    chk("df_count0", {56'd0, count0}, 64'd1);

    // Counter wrap on channel 3: one load then 256 back-to-back transfers
    sync_reset_pulse();
    for (int i = 0; i < 257; i++) step(1, 2'd3, 32'(i), 4'b1000);
    chk("wrap_count3", {56'd0, count3}, 64'd0);
    chk("wrap_count0", {56'd0, count0}, 64'd0);
    chk("wrap_count2", {56'd0, count2}, 64'd0);
    step(0, 2'd0, '0, 4'b1111);

`ifdef ALU_RESULT_DEMUX_FLAGS_EN
    step(1, 2'd1, 32'h8000_0000, 4'b0000);
    step(1, 2'd2, 32'h0, 4'b0000);
    chk("flags_neg", {60'd0, neg_flag}, 64'b0010);
    chk("flags_zero", {60'd0, zero_flag}, 64'b0100);
    step(0, 2'd0, '0, 4'b1111);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rand_word(),
           4'($urandom_range(0, 15)));
    end

    // Asynchronous reset with every channel full
    for (int k = 0; k < 4; k++) step(1, 2'(k), 32'hA5A5_0000 | 32'(k + 1), 4'b0000);
    chk("pre_rst_full", {60'd0, out_valid}, 64'hF);
    in_valid  = 0;
    out_ready = '0;
    #2;
    reset = 1;
    #1;
    chk("arst_out_valid", {60'd0, out_valid}, 64'h0);
    chk("arst_data0", {32'd0, data_out0}, 64'h0);
    chk("arst_data3", {32'd0, data_out3}, 64'h0);
    chk("arst_count", {32'd0, count0, count1, count2, count3}, 64'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 200; i++) begin
      step($urandom_range(0, 1) != 0, 2'($urandom_range(0, 3)), rand_word(),
           4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
